// File: rtl/alu_pkg.sv
// Shared function codes and widths for the PhilosophyV ALU.
// Optional shifter build macro: ALU_SHIFT_EN.
package alu_pkg;

    localparam int ALU_FUNCT_WIDTH = 4;
    localparam int ALU_NUM_FUNCT   = 10;

    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_AND  = 4'd0;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_OR   = 4'd1;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_XOR  = 4'd2;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_NOR  = 4'd3;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_ADD  = 4'd4;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SUB  = 4'd5;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SLT  = 4'd6;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SLTU = 4'd7;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SLL  = 4'd8;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SRL  = 4'd9;

    // Only ADD and SUB may report signed overflow.
    function automatic logic reports_overflow(input logic [ALU_FUNCT_WIDTH-1:0] funct);
        return (funct == ALU_FUNCT_ADD) || (funct == ALU_FUNCT_SUB);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// N-bit adder/subtractor: subtraction is a + ~b + 1, shared by SUB, SLT and SLTU.
module alu_addsub #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         overflow,
    output logic         carry
);

    logic [N-1:0] b_eff;

    always_comb begin
        b_eff = sub ? ~b : b;
        {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
        // Same-sign addends whose sum flips sign; with b inverted this also covers subtraction.
        overflow = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
    end

endmodule

// File: rtl/alu.sv
// Registered N-bit ALU: result mux, status flags and output registers.
// Define ALU_SHIFT_EN to build the SLL/SRL shifter; otherwise codes 8/9 act as unused codes.
module alu
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               x,
    input  logic [N-1:0]               y,
    input  logic [ALU_FUNCT_WIDTH-1:0] funct,
    output logic [N-1:0]               z,
    output logic                       equal,
    output logic                       zero,
    output logic                       overflow
);

    // No handshake: inputs are taken every rising edge and the registered
    // outputs for them are valid after that edge, one result per cycle.

`ifdef ALU_SHIFT_EN
    localparam int SHAMT_W = $clog2(N);
    logic [SHAMT_W-1:0] shamt;
    assign shamt = y[SHAMT_W-1:0];
`endif

    logic [N-1:0] z_d, z_q;
    logic         equal_d, equal_q;
    logic         zero_d, zero_q;
    logic         overflow_d, overflow_q;

    logic [N-1:0] as_sum;
    logic         as_ovf;
    logic         as_carry;
    logic         as_sub;

    assign as_sub = (funct != ALU_FUNCT_ADD);

    alu_addsub #(.N(N)) u_addsub (
        .a        (x),
        .b        (y),
        .sub      (as_sub),
        .sum      (as_sum),
        .overflow (as_ovf),
        .carry    (as_carry)
    );

    always_comb begin
        z_d = '0;
        case (funct)
            ALU_FUNCT_AND:  z_d = x & y;
            ALU_FUNCT_OR:   z_d = x | y;
            ALU_FUNCT_XOR:  z_d = x ^ y;
            ALU_FUNCT_NOR:  z_d = ~(x | y);
            ALU_FUNCT_ADD:  z_d = as_sum;
            ALU_FUNCT_SUB:  z_d = as_sum;
            // Signed less-than is the difference sign corrected by overflow; unsigned is the borrow.
            ALU_FUNCT_SLT:  z_d = {{(N-1){1'b0}}, as_sum[N-1] ^ as_ovf};
            ALU_FUNCT_SLTU: z_d = {{(N-1){1'b0}}, ~as_carry};
`ifdef ALU_SHIFT_EN
            ALU_FUNCT_SLL:  z_d = x << shamt;
            ALU_FUNCT_SRL:  z_d = x >> shamt;
`endif
            default:        z_d = '0;
        endcase

        equal_d    = (x == y);
        zero_d     = (z_d == '0);
        overflow_d = reports_overflow(funct) && as_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q        <= '0;
            equal_q    <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            z_q        <= z_d;
            equal_q    <= equal_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign z        = z_q;
    assign equal    = equal_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed spec cases plus random ops against a reference model.
module tb_alu;
    import alu_pkg::*;

    localparam int N = 32;
    localparam int W = N + 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] x, y;
    logic [3:0]   funct;
    logic [N-1:0] z;
    logic         equal, zero, overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    alu #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .y        (y),
        .funct    (funct),
        .z        (z),
        .equal    (equal),
        .zero     (zero),
        .overflow (overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Returns {z, equal, zero, overflow} for one operation, from the arithmetic rules.
    function automatic logic [W-1:0] ref_model(input logic [3:0] f, input logic [N-1:0] a,
                                               input logic [N-1:0] b);
        longint sa, sb, wide;
        logic [N-1:0] r;
        logic ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        ov = 1'b0;
        case (f)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: r = ~(a | b);
            4'd4: begin
                wide = sa + sb;
                r = a + b;
                ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd5: begin
                wide = sa - sb;
                r = a - b;
                ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd6: r = (sa < sb) ? 1 : 0;
            4'd7: r = (a < b) ? 1 : 0;
`ifdef ALU_SHIFT_EN
            4'd8: r = a << (b % N);
            4'd9: r = a >> (b % N);
`endif
            default: r = '0;
        endcase
        return {r, a == b, r == 0, ov};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic [3:0] f, input logic [N-1:0] a,
                         input logic [N-1:0] b);
        @(negedge clk);
        rst   = r;
        funct = f;
        x     = a;
        y     = b;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
            @(negedge clk);
            n_checks++;
            if ({z, equal, zero, overflow} !== {{N{1'b0}}, 3'b000}) begin
                n_errors++;
                $display("FAIL reset[%0d]: got z=%h eq=%b zr=%b ov=%b, want all zero",
                         i, z, equal, zero, overflow);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_logic();
        logic [3:0]   f_t[4]   = '{4'd0, 4'd1, 4'd2, 4'd3};
        logic [N-1:0] z_t[4]   = '{32'd1068, 32'd2047, 32'd979, 32'hFFFF_F800};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, f_t[i], 32'd1791, 32'd1324);
            @(negedge clk);
            n_checks++;
            if ({z, equal, zero, overflow} !== {z_t[i], 3'b000}) begin
                n_errors++;
                $display("FAIL logic f=%0d: got z=%h eq=%b zr=%b ov=%b, want z=%h eq=0 zr=0 ov=0",
                         f_t[i], z, equal, zero, overflow, z_t[i]);
            end
        end
    endtask

    task automatic test_arith();
        logic [3:0]   f_t[3] = '{4'd4, 4'd5, 4'd5};
        logic [N-1:0] a_t[3] = '{32'd1791, 32'd1791, 32'd1324};
        logic [N-1:0] b_t[3] = '{32'd1324, 32'd1324, 32'd1324};
        logic [W-1:0] e_t[3] = '{{32'd3115, 3'b000}, {32'd467, 3'b000}, {32'd0, 3'b110}};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, f_t[i], a_t[i], b_t[i]);
            @(negedge clk);
            n_checks++;
            if ({z, equal, zero, overflow} !== e_t[i]) begin
                n_errors++;
                $display("FAIL arith[%0d]: got {z,eq,zr,ov}=%h, want %h",
                         i, {z, equal, zero, overflow}, e_t[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [3:0]   f_t[3] = '{4'd4, 4'd5, 4'd0};
        logic [N-1:0] a_t[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        logic [N-1:0] b_t[3] = '{32'd1, 32'd1, 32'd1};
        logic [W-1:0] e_t[3] = '{{32'h8000_0000, 3'b001}, {32'h7FFF_FFFF, 3'b001},
                                 {32'h0, 3'b010}};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, f_t[i], a_t[i], b_t[i]);
            @(negedge clk);
            n_checks++;
            if ({z, equal, zero, overflow} !== e_t[i]) begin
                n_errors++;
                $display("FAIL overflow[%0d]: got {z,eq,zr,ov}=%h, want %h",
                         i, {z, equal, zero, overflow}, e_t[i]);
            end
        end
    endtask

    task automatic test_compare_shift();
        logic [3:0]   f_t[4] = '{4'd6, 4'd7, 4'd8, 4'd9};
        logic [N-1:0] a_t[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000};
        logic [N-1:0] b_t[4] = '{32'd1, 32'd1, 32'd33, 32'd31};
`ifdef ALU_SHIFT_EN
        logic [W-1:0] e_t[4] = '{{32'd1, 3'b000}, {32'd0, 3'b010}, {32'd2, 3'b000},
                                 {32'd1, 3'b000}};
`else
        logic [W-1:0] e_t[4] = '{{32'd1, 3'b000}, {32'd0, 3'b010}, {32'd0, 3'b010},
                                 {32'd0, 3'b010}};
`endif
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, f_t[i], a_t[i], b_t[i]);
            @(negedge clk);
            n_checks++;
            if ({z, equal, zero, overflow} !== e_t[i]) begin
                n_errors++;
                $display("FAIL cmp_shift f=%0d: got {z,eq,zr,ov}=%h, want %h",
                         f_t[i], {z, equal, zero, overflow}, e_t[i]);
            end
        end
    endtask

    task automatic test_unused_codes();
        for (int f = 10; f < 16; f++) begin
            drive(1'b0, 4'(f), 32'h7FFF_FFFF, 32'h7FFF_FFFF);
            @(negedge clk);
            n_checks++;
            if ({z, equal, zero, overflow} !== {32'd0, 3'b110}) begin
                n_errors++;
                $display("FAIL unused f=%0d: got {z,eq,zr,ov}=%h, want %h",
                         f, {z, equal, zero, overflow}, {32'd0, 3'b110});
            end
        end
    endtask

    // Back-to-back random ops with a reset pulse in the middle; each result is
    // checked one cycle after its inputs go in, while the next op is being driven.
    task automatic test_back_to_back();
        logic [W-1:0] exp;
        logic [N-1:0] a, b;
        logic [3:0]   f;
        logic         r;
        for (int i = 0; i < 300; i++) begin
            r = (i == 120) || (i == 121) || (i == 250);
            f = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            if ($urandom_range(0, 5) == 0) a = {1'b0, {(N-1){1'b1}}} - 32'($urandom_range(0, 3));
            drive(r, f, a, b);
            if (i > 0) begin
                exp = exp_q.pop_front();
                n_checks++;
                if ({z, equal, zero, overflow} !== exp) begin
                    n_errors++;
                    $display("FAIL b2b[%0d]: got {z,eq,zr,ov}=%h, want %h",
                             i - 1, {z, equal, zero, overflow}, exp);
                end
            end
            exp_q.push_back(r ? {W{1'b0}} : ref_model(f, a, b));
        end
        @(negedge clk);
        rst = 1'b0;
        exp = exp_q.pop_front();
        n_checks++;
        if ({z, equal, zero, overflow} !== exp) begin
            n_errors++;
            $display("FAIL b2b[last]: got {z,eq,zr,ov}=%h, want %h",
                     {z, equal, zero, overflow}, exp);
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 4'd4, 32'd10, 32'd20);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({z, equal, zero, overflow} !== {32'd30, 3'b000}) begin
                n_errors++;
                $display("FAIL hold[%0d]: got {z,eq,zr,ov}=%h, want %h",
                         i, {z, equal, zero, overflow}, {32'd30, 3'b000});
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst   = 1'b1;
        x     = '0;
        y     = '0;
        funct = '0;
        test_reset();
        test_logic();
        test_arith();
        test_overflow();
        test_compare_shift();
        test_unused_codes();
        test_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
